// File: rtl/instr_fetch.sv
// Instruction fetch unit: program memory plus a PC walker that offers one word at a
// time to the decoder and paces issue against the decoder's ready/busy status.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | after reset, waiting for start; program writes allowed
// FETCH    | registered memory read of mem[pc]
// ISSUE    | word offered (strobe high), waiting for decoder ready->busy edge
// ACCEPT   | decoder owns the word, waiting for it to return to ready
// COMPLETE | count the instruction, advance pc or finish
// DONE     | run finished normally; program writes / restart allowed
// ERROR    | decoder handshake timed out; program writes / restart allowed
module instr_fetch #(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [31:0] HALT_WORD = 32'h00000073,
    parameter int          TIMEOUT   = 255
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          decoder_rdy_bsy,
    output logic [31:0]   cpu_instruction,
    output logic          instruction_RDY_BSY,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          done,
    output logic          timeout_err,
    output logic [15:0]   issued_count
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_ACCEPT,
        S_COMPLETE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, state_next;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   len_q;
    logic [WW-1:0] wait_cnt;
    logic          armed;
    logic          idle_like;
    logic          take;
    logic          wait_exp;
    logic          last_word;

    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    // A fall only counts as acceptance once ready has been observed during this offer.
    assign take      = (state == S_ISSUE) && armed && !decoder_rdy_bsy;
    assign wait_exp  = (wait_cnt == WW'(TIMEOUT - 1));
    assign last_word = (cpu_instruction == HALT_WORD) ||
                       ((AW+1)'(pc) + (AW+1)'(1) == len_q);

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: state_next = S_ISSUE;
            S_ISSUE: begin
                if (take)          state_next = S_ACCEPT;
                else if (wait_exp) state_next = S_ERROR;
            end
            S_ACCEPT: begin
                if (decoder_rdy_bsy) state_next = S_COMPLETE;
                else if (wait_exp)   state_next = S_ERROR;
            end
            S_COMPLETE: state_next = last_word ? S_DONE : S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        instruction_RDY_BSY = (state == S_ISSUE);
        running             = (state == S_ISSUE) || (state == S_ACCEPT) || (state == S_COMPLETE);
        done                = (state == S_DONE);
        timeout_err         = (state == S_ERROR);
    end

    always_ff @(posedge cpu_clk) begin
        if (prog_we && idle_like) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc              <= '0;
            cpu_instruction <= '0;
            issued_count    <= '0;
            len_q           <= '0;
            wait_cnt        <= '0;
            armed           <= 1'b0;
        end else begin
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state == S_ISSUE || state == S_ACCEPT) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        len_q        <= (prog_len == '0) ? (AW+1)'(DEPTH) : prog_len;
                        pc           <= '0;
                        issued_count <= '0;
                    end
                end
                S_FETCH: begin
                    cpu_instruction <= mem[pc];
                    armed           <= decoder_rdy_bsy;
                end
                S_ISSUE: begin
                    armed <= armed | decoder_rdy_bsy;
                end
                S_COMPLETE: begin
                    if (issued_count != 16'hFFFF) issued_count <= issued_count + 16'd1;
                    if (!last_word) pc <= pc + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: auto-responding decoder model plus hand-driven
// decoder sequences, strobe log, and immediate assertions against hand-computed values.
module tb_instr_fetch;
    localparam int AW = 6;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic          decoder_rdy_bsy;
    logic [31:0]   cpu_instruction;
    logic          instruction_RDY_BSY;
    logic [AW-1:0] pc;
    logic          running;
    logic          done;
    logic          timeout_err;
    logic [15:0]   issued_count;

    int errors = 0;
    int checks = 0;

    logic auto_dec = 1'b0;
    logic dec_auto = 1'b1;
    logic dec_man  = 1'b1;
    int   busy_cnt = 0;
    logic strb_q   = 1'b0;
    logic [31:0]   log_instr [$];
    logic [AW-1:0] log_pc [$];

    assign decoder_rdy_bsy = auto_dec ? dec_auto : dec_man;

    instr_fetch dut (
        .cpu_clk             (cpu_clk),
        .cpu_rst             (cpu_rst),
        .prog_we             (prog_we),
        .prog_addr           (prog_addr),
        .prog_wdata          (prog_wdata),
        .prog_len            (prog_len),
        .start               (start),
        .decoder_rdy_bsy     (decoder_rdy_bsy),
        .cpu_instruction     (cpu_instruction),
        .instruction_RDY_BSY (instruction_RDY_BSY),
        .pc                  (pc),
        .running             (running),
        .done                (done),
        .timeout_err         (timeout_err),
        .issued_count        (issued_count)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Decoder goes busy one cycle after seeing the strobe, ready again two cycles later.
    always @(negedge cpu_clk) begin
        if (auto_dec) begin
            if (busy_cnt != 0) begin
                busy_cnt--;
                if (busy_cnt == 0) dec_auto = 1'b1;
            end else if (instruction_RDY_BSY && dec_auto) begin
                dec_auto = 1'b0;
                busy_cnt = 2;
            end
        end
    end

    always @(negedge cpu_clk) begin
        if (instruction_RDY_BSY && !strb_q) begin
            log_instr.push_back(cpu_instruction);
            log_pc.push_back(pc);
        end
        strb_q = instruction_RDY_BSY;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge cpu_clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge cpu_clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW:0] len);
        @(negedge cpu_clk);
        prog_len = len; start = 1'b1;
        @(negedge cpu_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done && !timeout_err && n < max) begin
            @(posedge cpu_clk); #1; n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        while (!instruction_RDY_BSY && n < 20) begin
            @(posedge cpu_clk); #1; n++;
        end
        check(tag, 32'(instruction_RDY_BSY), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        logic [31:0] prog3 [3];
        logic [31:0] halt4 [4];
        logic [31:0] abc [3];
        prog3 = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        halt4 = '{32'h00000011, 32'h00000073, 32'h00000022, 32'h00000033};
        abc   = '{32'hA0A00001, 32'hB0B00002, 32'hC0C00003};

        cpu_rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        prog_len = '0; start = 1'b0;
        #12;
        check("rst_strobe", 32'(instruction_RDY_BSY), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", cpu_instruction, 32'd0);
        check("rst_count", 32'(issued_count), 32'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // Three-word program with the auto decoder
        for (int i = 0; i < 3; i++) write_word(AW'(i), prog3[i]);
        auto_dec = 1'b1;
        base = log_instr.size();
        pulse_start(7'd3);
        wait_done("p3_done", 200);
        check("p3_nstrobes", 32'(log_instr.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("p3_instr%0d", i), log_instr[base+i], prog3[i]);
            check($sformatf("p3_pc%0d", i), 32'(log_pc[base+i]), 32'(i));
        end
        check("p3_count", 32'(issued_count), 32'd3);
        check("p3_pc_end", 32'(pc), 32'd2);
        check("p3_strobe_off", 32'(instruction_RDY_BSY), 32'd0);

        // Halt word at address 1 ends the run early
        for (int i = 0; i < 4; i++) write_word(AW'(i), halt4[i]);
        base = log_instr.size();
        pulse_start(7'd4);
        wait_done("halt_done", 200);
        check("halt_nstrobes", 32'(log_instr.size() - base), 32'd2);
        check("halt_count", 32'(issued_count), 32'd2);
        check("halt_pc", 32'(pc), 32'd1);
        check("halt_instr", cpu_instruction, 32'h00000073);

        // Decoder stuck ready: timeout exactly 255 cycles after the strobe rises
        auto_dec = 1'b0; dec_man = 1'b1;
        pulse_start(7'd4);
        check("to_done_cleared", 32'(done), 32'd0);
        wait_strobe("to_strobe");
        n = 0;
        while (!timeout_err && n < 400) begin
            @(posedge cpu_clk); #1; n++;
        end
        check("to_cycles", 32'(n), 32'd255);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_strobe_off", 32'(instruction_RDY_BSY), 32'd0);
        check("to_pc", 32'(pc), 32'd0);
        check("to_running", 32'(running), 32'd0);

        // Stale busy at issue: no acceptance until ready then busy is seen
        dec_man = 1'b0;
        pulse_start(7'd1);
        check("stale_err_cleared", 32'(timeout_err), 32'd0);
        wait_strobe("stale_strobe");
        repeat (10) @(negedge cpu_clk);
        check("stale_held", 32'(instruction_RDY_BSY), 32'd1);
        check("stale_count0", 32'(issued_count), 32'd0);
        dec_man = 1'b1;
        repeat (2) @(negedge cpu_clk);
        check("stale_still_offered", 32'(instruction_RDY_BSY), 32'd1);
        dec_man = 1'b0;
        @(negedge cpu_clk);
        check("stale_accept_strobe", 32'(instruction_RDY_BSY), 32'd0);
        check("stale_accept_running", 32'(running), 32'd1);
        check("stale_no_early_count", 32'(issued_count), 32'd0);
        dec_man = 1'b1;
        wait_done("stale_done", 50);
        check("stale_count1", 32'(issued_count), 32'd1);

        // Program write during a run is dropped; reset mid-ACCEPT aborts at once
        for (int i = 0; i < 3; i++) write_word(AW'(i), abc[i]);
        dec_man = 1'b1;
        pulse_start(7'd3);
        wait_strobe("rst_run_strobe");
        write_word(AW'(1), 32'hDEADBEEF);
        @(negedge cpu_clk);
        dec_man = 1'b0;
        @(negedge cpu_clk);
        check("mid_accept_running", 32'(running), 32'd1);
        check("mid_accept_strobe", 32'(instruction_RDY_BSY), 32'd0);
        #2 cpu_rst = 1'b1;
        #1;
        check("arst_running", 32'(running), 32'd0);
        check("arst_strobe", 32'(instruction_RDY_BSY), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0; dec_man = 1'b1;
        auto_dec = 1'b1;
        base = log_instr.size();
        pulse_start(7'd3);
        wait_done("rerun_done", 200);
        check("rerun_nstrobes", 32'(log_instr.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rerun_instr%0d", i), log_instr[base+i], abc[i]);
        end

        // prog_len = 0 runs the full memory
        for (int i = 0; i < 64; i++) write_word(AW'(i), 32'h10000000 + 32'(i));
        base = log_instr.size();
        pulse_start(7'd0);
        wait_done("full_done", 2000);
        check("full_nstrobes", 32'(log_instr.size() - base), 32'd64);
        check("full_count", 32'(issued_count), 32'd64);
        check("full_pc", 32'(pc), 32'd63);
        check("full_last_instr", log_instr[base+63], 32'h1000003F);
        check("full_last_pc", 32'(log_pc[base+63]), 32'd63);
        check("full_mid_instr", log_instr[base+40], 32'h10000028);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
